kitchen_timer_ctrl: RTL and testbench

Sequencing controller for the kitchen timer. It consumes a single-cycle 1 Hz enable pulse derived from the board clock-divider chain, plus debounced single-cycle button pulses. It runs the set/run/pause/alarm state machine and holds the minutes:seconds count. Its outputs drive the display mux and the buzzer/LED logic.

---
 rtl/kitchen_timer_ctrl.sv | 117 +++++++++++
 tb/tb_kitchen_timer_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/kitchen_timer_ctrl.sv
// rtl/kitchen_timer_ctrl.sv - kitchen timer set/run/pause/alarm sequencer with mm:ss countdown
module kitchen_timer_ctrl #(
    parameter int MAX_MIN    = 99,
    parameter int ALARM_SECS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_min,
    input  logic       btn_sec,
    input  logic       btn_start,
    input  logic       btn_clr,
    output logic [6:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] state,
    output logic       running,
    output logic       alarm,
    output logic       blink
);

    typedef enum logic [1:0] {
        S_SET   = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    // Counter holds ticks already spent in ALARM, so it tops out at ALARM_SECS-1.
    localparam int              CW      = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [CW-1:0]   CNT_TOP = CW'(ALARM_SECS - 1);
    localparam logic [6:0]      MIN_TOP = 7'(MAX_MIN);

    state_t        state_q;
    logic [CW-1:0] alarm_cnt;
    logic          any_btn;

    assign any_btn = btn_clr | btn_start | btn_min | btn_sec;
    assign state   = state_q;
    assign running = (state_q == S_RUN);
    assign alarm   = (state_q == S_ALARM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_SET;
            minutes   <= '0;
            seconds   <= '0;
            blink     <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            case (state_q)
                S_SET: begin
                    if (btn_clr) begin
                        minutes <= '0;
                        seconds <= '0;
                    end else if (btn_start) begin
                        if (minutes != '0 || seconds != '0)
                            state_q <= S_RUN;
                    end else begin
                        if (btn_min)
                            minutes <= (minutes >= MIN_TOP) ? 7'd0 : minutes + 7'd1;
                        if (btn_sec)
                            seconds <= (seconds >= 6'd59) ? 6'd0 : seconds + 6'd1;
                    end
                end
                S_RUN: begin
                    if (btn_clr) begin
                        state_q <= S_SET;
                        minutes <= '0;
                        seconds <= '0;
                    end else if (btn_start) begin
                        state_q <= S_PAUSE;
                    end else if (tick) begin
                        // Reaching 00:00 enters ALARM on the same edge as the last decrement.
                        if (seconds != '0) begin
                            seconds <= seconds - 6'd1;
                            if (minutes == '0 && seconds == 6'd1) begin
                                state_q   <= S_ALARM;
                                blink     <= 1'b0;
                                alarm_cnt <= '0;
                            end
                        end else if (minutes != '0) begin
                            minutes <= minutes - 7'd1;
                            seconds <= 6'd59;
                        end else begin
                            state_q   <= S_ALARM;
                            blink     <= 1'b0;
                            alarm_cnt <= '0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (btn_clr) begin
                        state_q <= S_SET;
                        minutes <= '0;
                        seconds <= '0;
                    end else if (btn_start) begin
                        state_q <= S_RUN;
                    end
                end
                S_ALARM: begin
                    minutes <= '0;
                    seconds <= '0;
                    if (any_btn || (tick && alarm_cnt == CNT_TOP)) begin
                        state_q   <= S_SET;
                        blink     <= 1'b0;
                        alarm_cnt <= '0;
                    end else if (tick) begin
                        blink     <= ~blink;
                        alarm_cnt <= alarm_cnt + 1'b1;
                    end
                end
                default: state_q <= S_SET;
            endcase
        end
    end

endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
// tb/tb_kitchen_timer_ctrl.sv - scoreboard bench for kitchen_timer_ctrl against a behavioural timer model
module tb_kitchen_timer_ctrl;

    localparam int MAX_MIN    = 99;
    localparam int ALARM_SECS = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0, btn_min = 1'b0, btn_sec = 1'b0, btn_start = 1'b0, btn_clr = 1'b0;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic [1:0] state;
    logic       running, alarm, blink;

    kitchen_timer_ctrl #(.MAX_MIN(MAX_MIN), .ALARM_SECS(ALARM_SECS)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .btn_min(btn_min), .btn_sec(btn_sec), .btn_start(btn_start), .btn_clr(btn_clr),
        .minutes(minutes), .seconds(seconds), .state(state),
        .running(running), .alarm(alarm), .blink(blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mn;
        int sc;
        int st;
        bit bl;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference model: 0=SET 1=RUN 2=PAUSE 3=ALARM; alarm_ticks counts ticks seen in ALARM.
    int m_st = 0, m_mn = 0, m_sc = 0, alarm_ticks = 0;
    bit m_bl = 0;

    function automatic void model_zero();
        m_st = 0; m_mn = 0; m_sc = 0; m_bl = 0; alarm_ticks = 0;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.mn = m_mn; e.sc = m_sc; e.st = m_st; e.bl = m_bl;
        sb.push_back(e);
    endfunction

    function automatic void model_step(bit t, bit bm, bit bs, bit bst, bit bc);
        int total;
        case (m_st)
            0: begin
                if (bc) begin m_mn = 0; m_sc = 0; end
                else if (bst) begin if (m_mn * 60 + m_sc > 0) m_st = 1; end
                else begin
                    if (bm) m_mn = (m_mn + 1) % (MAX_MIN + 1);
                    if (bs) m_sc = (m_sc + 1) % 60;
                end
            end
            1: begin
                if (bc) begin m_st = 0; m_mn = 0; m_sc = 0; end
                else if (bst) m_st = 2;
                else if (t) begin
                    total = m_mn * 60 + m_sc - 1;
                    if (total < 0) total = 0;
                    m_mn = total / 60;
                    m_sc = total % 60;
                    if (total == 0) begin m_st = 3; m_bl = 0; alarm_ticks = 0; end
                end
            end
            2: begin
                if (bc) begin m_st = 0; m_mn = 0; m_sc = 0; end
                else if (bst) m_st = 1;
            end
            default: begin
                if (bc || bst || bm || bs) model_zero();
                else if (t) begin
                    alarm_ticks++;
                    if (alarm_ticks >= ALARM_SECS) model_zero();
                    else m_bl = ~m_bl;
                end
            end
        endcase
    endfunction

    task automatic drive(input bit t, input bit bm, input bit bs, input bit bst, input bit bc);
        @(negedge clk);
        tick = t; btn_min = bm; btn_sec = bs; btn_start = bst; btn_clr = bc;
        model_step(t, bm, bs, bst, bc);
        push_exp();
    endtask

    task automatic idle_all();
        @(negedge clk);
        tick = 0; btn_min = 0; btn_sec = 0; btn_start = 0; btn_clr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        tick = 0; btn_min = 0; btn_sec = 0; btn_start = 0; btn_clr = 0;
        #2 reset = 1'b0;
        #1;
        tests++;
        if (minutes !== 7'd0 || seconds !== 6'd0 || state !== 2'd0 || running !== 1'b0 ||
            alarm !== 1'b0 || blink !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got %0d:%0d st=%0d run=%0b alm=%0b blk=%0b, want 0:0 st=0 all flags 0",
                     minutes, seconds, state, running, alarm, blink);
        end
        model_zero();
        push_exp();
        repeat (2) begin @(negedge clk); push_exp(); end
        @(negedge clk);
        reset = 1'b1;
        push_exp();
    endtask

    task automatic press(input int n, input bit bm, input bit bs);
        repeat (n) drive(0, bm, bs, 0, 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) drive(1, 0, 0, 0, 0);
    endtask

    // Monitor: every clock edge is an output presentation; compare with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (minutes !== 7'(e.mn) || seconds !== 6'(e.sc) || state !== 2'(e.st) ||
                    running !== (e.st == 1) || alarm !== (e.st == 3) || blink !== e.bl) begin
                    fails++;
                    $display("FAIL cycle %0d: got %0d:%0d st=%0d run=%0b alm=%0b blk=%0b, want %0d:%0d st=%0d blk=%0b",
                             cyc, minutes, seconds, state, running, alarm, blink, e.mn, e.sc, e.st, e.bl);
                end
            end
        end
    end

    initial begin
        int budget;
        do_reset();

        // 01:30 running, then asynchronous reset
        press(1, 1, 0); press(30, 0, 1); drive(0, 0, 0, 1, 0);
        do_reset();

        // 03:01 via seconds wrap, then two ticks
        press(3, 1, 0); press(61, 0, 1); drive(0, 0, 0, 1, 0); ticks(2);
        drive(0, 0, 0, 0, 1);

        // start ignored at 00:00, minutes wrap
        drive(0, 0, 0, 1, 0); press(100, 1, 0); press(1, 1, 1);
        drive(0, 0, 0, 0, 1);

        // countdown into ALARM, blink, button exit
        press(2, 0, 1); drive(0, 0, 0, 1, 0); ticks(2); ticks(3); press(1, 0, 1);

        // pause with simultaneous tick, resume
        press(10, 0, 1); drive(0, 0, 0, 1, 0); drive(1, 0, 0, 1, 0); ticks(5);
        drive(0, 0, 0, 1, 0); ticks(1); drive(0, 0, 0, 0, 1);

        // full alarm timeout
        press(1, 0, 1); drive(0, 0, 0, 1, 0); ticks(1); ticks(ALARM_SECS); ticks(1);

        // clr beats start in RUN
        press(5, 0, 1); drive(0, 0, 0, 1, 0); drive(1, 0, 0, 1, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit t, bm, bs, bst, bc;
            t   = ($urandom_range(0, 2) == 0);
            bm  = ($urandom_range(0, 9) == 0);
            bs  = ($urandom_range(0, 3) == 0);
            bst = ($urandom_range(0, 29) == 0);
            bc  = ($urandom_range(0, 99) == 0);
            drive(t, bm, bs, bst, bc);
        end
        idle_all();

        budget = 20;
        while (sb.size() > 0 && budget > 0) begin @(negedge clk); budget--; end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
